n_ser_feeder: RTL and testbench
===============================

N_SER_FEEDER -- requirements
Module: n_ser_feeder

Interface
REQ-001 SHALL have parameter N, default 8: data word width in bits, legal range N >= 2.
REQ-002 SHALL have parameter GAP, default 0: idle cycles inserted after each frame, legal range 0..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  input  N  parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1  din holds a valid word.
REQ-007 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port dir  input  1  bit order: 0 = MSB first, 1 = LSB first.
REQ-009 SHALL have port sout_bit  output  1  serial data bit, drives a downstream shift register's serial input.
REQ-010 SHALL have port sout_valid  output  1  sout_bit is valid this cycle, usable as the downstream shift enable.
REQ-011 SHALL have port sout_last  output  1  final bit of the current frame.
REQ-012 SHALL have port busy  output  1  a frame or gap is in progress.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT, PAR and GAP; PAR exists only under REQ-027.
REQ-014 SHALL drive din_ready high exactly when the state is IDLE; a word is accepted on a clock edge where din_valid && din_ready.
REQ-015 SHALL capture din and dir on acceptance, then go IDLE->SHIFT; later changes to din or dir SHALL NOT affect the frame in progress.
REQ-016 SHALL, in SHIFT, output one bit per cycle for exactly N cycles with sout_valid = 1, the first bit in the cycle after acceptance.
REQ-017 SHALL, with captured dir = 0, send bits in order din[N-1] down to din[0]; with captured dir = 1, send din[0] up to din[N-1].
REQ-018 SHALL keep a bit counter of width $clog2(N) that wraps to 0 on frame end; it SHALL NOT overrun N-1.
REQ-019 SHALL, after the final frame bit, enter GAP for GAP cycles if GAP > 0, otherwise IDLE; in GAP, sout_valid = 0 and busy = 1.
REQ-020 SHALL assert sout_last for exactly one cycle, coincident with the final sout_valid cycle of the frame.
REQ-021 SHALL drive sout_bit = 0 whenever sout_valid = 0.
REQ-022 SHALL assert busy in every non-IDLE state; busy = !din_ready.
REQ-023 SHALL have a frame period of 1 + N + GAP cycles from acceptance to the next acceptance, plus 1 cycle under REQ-027, when din_valid is held high.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, counter 0 and captured word 0.
REQ-025 SHALL, during reset, hold outputs at sout_bit = 0, sout_valid = 0, sout_last = 0 and busy = 0; din_ready SHALL be 1 after rst_n deasserts.
REQ-026 SHALL discard any partial frame on a mid-frame reset; no bits of that frame SHALL be emitted after reset.

Configuration
REQ-027 SHALL, when macro N_SER_FEEDER_PARITY_EN is defined, enter PAR after the N-th data bit for one cycle, outputting sout_bit = ^captured_word (even parity) with sout_valid = 1 and sout_last = 1; the N-th data bit SHALL then have sout_last = 0.
REQ-028 SHALL, when N_SER_FEEDER_PARITY_EN is undefined, contain no PAR state or parity logic, and each frame SHALL be exactly N valid bits.

Verification
REQ-029 SHALL cover: N=8, GAP=0, din=8'hC1 with dir=0 -> sout_bit 1,1,0,0,0,0,0,1 on cycles T+1..T+8, sout_last at T+8, din_ready high again at T+9.
REQ-030 SHALL cover: din=8'hC1 with dir=1, and dir toggled at T+3 -> sout_bit 1,0,0,0,0,0,1,1, unaffected by the toggle.
REQ-031 SHALL cover: parity enabled, din=8'hC1 -> 8 data bits with sout_last = 0, then a parity bit of 1 with sout_last = 1 at T+9, and the next acceptance at T+10.
REQ-032 SHALL cover: GAP=2, din_valid held high with words 8'h01 then 8'h80 -> second acceptance at T+11, sout_valid low at T+9 and T+10, busy high throughout.
REQ-033 SHALL cover: rst_n pulsed low at T+4 of a frame -> all outputs 0 at once, din_ready = 1 after release, and a fresh word serializes correctly.
REQ-034 SHALL cover: dir=0 output fed into a downstream 8-bit left shift register shifting on sout_valid -> the register holds 8'hC1 after sout_last.

Source files
------------

// File: rtl/n_ser_feeder.sv
// n_ser_feeder: parallel-to-serial feeder for a downstream shift register.
// Accepts an N-bit word when idle and emits it one bit per cycle, MSB or LSB first.
// After each frame it inserts GAP idle cycles before accepting the next word.
// Optional feature: define N_SER_FEEDER_PARITY_EN to append one even-parity bit per frame.

module n_ser_feeder #(
    parameter int unsigned N   = 8,
    parameter int unsigned GAP = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         dir,
    output logic         sout_bit,
    output logic         sout_valid,
    output logic         sout_last,
    output logic         busy
);

    localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);
    // Gap counter is preloaded with GAP-1 and counts down to 0, giving GAP idle cycles.
    localparam logic [3:0]    GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
`ifdef N_SER_FEEDER_PARITY_EN
        ,
        StPar   = 2'd3
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  word_q, word_d;
    logic          dir_q, dir_d;
    logic [3:0]    gap_q, gap_d;

    logic [CW-1:0] bit_idx;
    logic          sel_bit;

    // Select the frame bit for the current count; the captured dir picks the order.
    always_comb begin
        bit_idx = dir_q ? cnt_q : (LastCnt - cnt_q);
        sel_bit = word_q[bit_idx];
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        dir_d      = dir_q;
        gap_d      = gap_q;
        din_ready  = 1'b0;
        busy       = 1'b1;
        sout_valid = 1'b0;
        sout_bit   = 1'b0;
        sout_last  = 1'b0;

        case (state_q)
            StIdle: begin
                din_ready = 1'b1;
                busy      = 1'b0;
                if (din_valid) begin
                    word_d  = din;
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end

            StShift: begin
                sout_valid = 1'b1;
                sout_bit   = sel_bit;
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
`ifdef N_SER_FEEDER_PARITY_EN
                    state_d = StPar;
`else
                    sout_last = 1'b1;
                    if (GAP > 0) begin
                        state_d = StGap;
                        gap_d   = GapLoad;
                    end else begin
                        state_d = StIdle;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

`ifdef N_SER_FEEDER_PARITY_EN
            StPar: begin
                sout_valid = 1'b1;
                sout_bit   = ^word_q;
                sout_last  = 1'b1;
                if (GAP > 0) begin
                    state_d = StGap;
                    gap_d   = GapLoad;
                end else begin
                    state_d = StIdle;
                end
            end
`endif

            StGap: begin
                if (gap_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset drops any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_n_ser_feeder.sv
// Testbench for n_ser_feeder: two instances (GAP=0 and GAP=2) share din/dir.
// A frame-position model predicts every output each cycle; directed frames add literal checks.

module tb_n_ser_feeder;

`ifdef N_SER_FEEDER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dir = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_valid2 = 1'b0;

    logic rdy0, bit0, vld0, last0, busy0;
    logic rdy2, bit2, vld2, last2, busy2;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    n_ser_feeder #(.N(8), .GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy0),
        .dir(dir), .sout_bit(bit0), .sout_valid(vld0), .sout_last(last0), .busy(busy0)
    );

    n_ser_feeder #(.N(8), .GAP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid2), .din_ready(rdy2),
        .dir(dir), .sout_bit(bit2), .sout_valid(vld2), .sout_last(last2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is a list of output cycles: 8 data bits, optional parity, then gap cycles.
    function automatic int flen(input int gap);
        return 8 + PAR + gap;
    endfunction

    // Expected {valid, bit, last, busy, ready} at position k of a frame.
    function automatic logic [4:0] expect_obs(input bit act, input int k,
                                              input logic [7:0] w, input logic d);
        logic v, b, l;
        v = 1'b0; b = 1'b0; l = 1'b0;
        if (!act) return 5'b00001;
        if (k < 8) begin
            v = 1'b1;
            b = d ? w[k] : w[7-k];
            l = (k == 7) && (PAR == 0);
        end else if (k == 8 && PAR == 1) begin
            v = 1'b1;
            b = ^w;
            l = 1'b1;
        end
        return {v, b, l, 1'b1, 1'b0};
    endfunction

    bit         m_act[2];
    int         m_k[2];
    logic [7:0] m_w[2];
    logic       m_d[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0;
                m_k[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i]) begin
                    if (m_k[i] + 1 == flen(i == 0 ? 0 : 2)) m_act[i] <= 1'b0;
                    m_k[i] <= m_k[i] + 1;
                end else if ((i == 0) ? din_valid : din_valid2) begin
                    m_act[i] <= 1'b1;
                    m_k[i]   <= 0;
                    m_w[i]   <= din;
                    m_d[i]   <= dir;
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dut0_outputs", 32'({vld0, bit0, last0, busy0, rdy0}),
                  32'(expect_obs(m_act[0], m_k[0], m_w[0], m_d[0])));
            check("dut2_outputs", 32'({vld2, bit2, last2, busy2, rdy2}),
                  32'(expect_obs(m_act[1], m_k[1], m_w[1], m_d[1])));
        end
    end

    // Downstream 8-bit left shift register fed by dut0.
    logic [7:0] sr = 8'h00;
    always @(posedge clk) begin
        if (vld0) sr <= {sr[6:0], bit0};
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Sends w on dut0; exp lists the serial bits in emission order (exp[7] first).
    // dir is toggled at T+3 to show the captured order is kept.
    task automatic run_frame0(input logic [7:0] w, input logic d, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'h00;
        step();
        din = w; dir = d; din_valid = 1'b1;
        sample();
        check("accept_ready", 32'(rdy0), 32'd1);
        step();
        din_valid = 1'b0;
        din = ~w;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) dir = ~dir;
            sample();
            got[7-i] = bit0;
            if (i == 7) check("last_on_final_data", 32'(last0), 32'(PAR == 0));
            step();
        end
        sample();
        check("bit_sequence", 32'(got), 32'(exp));
        check("downstream_sr", 32'(sr), 32'(exp));
`ifdef N_SER_FEEDER_PARITY_EN
        check("parity_bit", 32'(bit0), 32'(^w));
        check("parity_last", 32'(last0), 32'd1);
        step();
        sample();
`endif
        check("ready_after_frame", 32'(rdy0), 32'd1);
    endtask

    initial begin
        bit busy_ok;
        chk_en = 1'b1;
        sample();
        check("reset_outputs0", 32'({vld0, bit0, last0, busy0}), 32'd0);
        check("reset_outputs2", 32'({vld2, bit2, last2, busy2}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        sample();
        check("ready_after_reset", 32'({rdy0, rdy2}), 32'b11);

        // MSB first and LSB first with the same word.
        run_frame0(8'hC1, 1'b0, 8'hC1);
        run_frame0(8'hC1, 1'b1, 8'h83);
        run_frame0(8'h96, 1'b1, 8'h69);
        run_frame0(8'h96, 1'b0, 8'h96);
        run_frame0(8'h00, 1'b0, 8'h00);
        run_frame0(8'hFF, 1'b1, 8'hFF);

        // GAP=2 instance with din_valid held high: 01 then 80.
        step();
        din = 8'h01; dir = 1'b0; din_valid2 = 1'b1;
        sample();
        check("gap_first_accept", 32'(rdy2), 32'd1);
        step();
        din = 8'h80;
        busy_ok = 1'b1;
        for (int c = 1; c <= 10 + PAR; c++) begin
            if (c > 1) step();
            sample();
            if (!busy2) busy_ok = 1'b0;
            if (c > 8 + PAR) check("gap_valid_low", 32'(vld2), 32'd0);
            if (c < 11 + PAR) check("gap_not_ready", 32'(rdy2), 32'd0);
        end
        step();
        sample();
        check("gap_second_accept", 32'(rdy2), 32'd1);
        check("gap_busy_throughout", 32'(busy_ok), 32'd1);
        step();
        din_valid2 = 1'b0;
        repeat (12) step();

        // Mid-frame reset at T+4.
        step();
        din = 8'hA5; dir = 1'b0; din_valid = 1'b1; din_valid2 = 1'b1;
        step();
        din_valid = 1'b0; din_valid2 = 1'b0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs0", 32'({vld0, bit0, last0, busy0}), 32'd0);
        check("midreset_outputs2", 32'({vld2, bit2, last2, busy2}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        sample();
        check("midreset_ready", 32'({rdy0, rdy2}), 32'b11);
        sample();
        check("no_bits_after_reset", 32'({vld0, vld2}), 32'd0);
        run_frame0(8'hC1, 1'b0, 8'hC1);

        repeat (4) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
